stopwatch_display: RTL and testbench
====================================

# stopwatch_display

Consumes the one-cycle seconds tick produced by the stopwatch timebase and keeps elapsed time as four BCD digits (MM:SS, 00:00 to 59:59) with run/pause and reset control. Drives a 4-digit multiplexed seven-segment display, with digit selection advanced by a separate scan tick. Sits between the timebase/counter stage and the board display pins, and is the receiving end of the carry/tick pulses that stage generates.

## Interface
- SEG_ACTIVE_LOW, 1: 1 means SEG and AN are active-low (board default); 0 inverts both.
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- TICK  input  1  one-cycle enable, one per elapsed second.
- PAUSE  input  1  one-cycle pulse (already debounced); toggles run/pause.
- SCAN_TICK  input  1  one-cycle enable; advances the display digit.
- DIGITS  output  16  BCD time {min_tens, min_ones, sec_tens, sec_ones}, [15:12] down to [3:0].
- RUNNING  output  1  1 = counting, 0 = paused.
- ROLLOVER  output  1  one-cycle pulse when time wraps 59:59 -> 00:00.
- SEG  output  7  segments {g,f,e,d,c,b,a} for the selected digit.
- AN  output  4  digit enables, one-hot (polarity per SEG_ACTIVE_LOW).

## Operation
- Run FSM has two states, PAUSED and RUN. RESET forces PAUSED.
- PAUSE pulse: PAUSED -> RUN or RUN -> PAUSED. With no pulse, the state holds.
- TICK in RUN increments the time. TICK in PAUSED is ignored (dropped, not queued).
- TICK and PAUSE in the same cycle: the increment decision uses the state before the toggle. A tick in RUN counts and the state then moves to PAUSED; a tick in PAUSED is ignored and the state then moves to RUN.
- Increment is a BCD cascade:
  - sec_ones 0-9; carry into sec_tens 0-5.
  - carry into min_ones 0-9; carry into min_tens 0-5.
  - 59:59 + 1 = 00:00 with ROLLOVER = 1 for that one cycle.
- Digits never hold a non-BCD value, and tens digits never exceed 5.
- Scan index is a 2-bit counter, 0 to 3, advanced by SCAN_TICK and wrapping 3 -> 0. The scan runs regardless of RUNNING.
  - Index 0 selects sec_ones on AN[0].
  - Index 1 selects sec_tens on AN[1].
  - Index 2 selects min_ones on AN[2].
  - Index 3 selects min_tens on AN[3].
- SEG decode, active-high patterns {g..a}:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Inverted when SEG_ACTIVE_LOW = 1.

## Timing
- Reset values, applied asynchronously on RESET high:
  - DIGITS = 16'h0000, RUNNING = 0, ROLLOVER = 0, scan index = 0.
  - SEG = pattern for 0, AN = digit 0 selected (4'b1110 when active-low).
- Reset mid-count clears everything immediately, without waiting for a CLK edge.
- Ticks arriving while RESET is high are lost.
- Latency: TICK sampled high at edge N means DIGITS and ROLLOVER show the new value after edge N.
- ROLLOVER is high for exactly one cycle.
- PAUSE sampled at edge N means RUNNING changes after edge N.
- SEG and AN are registered. After SCAN_TICK at edge N, AN and SEG show the new digit after edge N.
- A DIGITS change at edge N shows on SEG after edge N+1 (one extra cycle).
- AN is always exactly one-hot outside reset, with no all-off or multi-on cycles.
- Back-to-back TICKs on consecutive cycles are legal; each one counts.

## Test plan
- Reset release, no pulses -> DIGITS = 0000, RUNNING = 0, AN = 1110, SEG = 1000000 (active-low 0).
- PAUSE, then 10 TICKs on consecutive cycles -> DIGITS = 0010 (00:10), RUNNING = 1, ROLLOVER never high.
- Run from 00:00 with 3599 TICKs -> DIGITS = 5959; one more TICK -> DIGITS = 0000 with ROLLOVER high for exactly 1 cycle.
- In RUN at 00:05, assert PAUSE and TICK together -> DIGITS = 0006, RUNNING = 0. Three further TICKs -> DIGITS stays 0006. PAUSE and TICK together again -> DIGITS stays 0006, RUNNING = 1.
- At 12:34 in RUN, pulse RESET between clock edges -> DIGITS = 0000 and RUNNING = 0 before the next CLK edge. TICK during RESET is ignored.
- At 12:34, issue 5 SCAN_TICKs -> AN sequence 1101, 1011, 0111, 1110, 1101 with SEG = decodes of 3, 2, 1, 4, 3 (active-low).

Source files
------------

// File: rtl/stopwatch_display.sv
// stopwatch_display: MM:SS BCD stopwatch with run/pause control and multiplexed seven-segment drive
module stopwatch_display #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        TICK,
   input  logic        PAUSE,
   input  logic        SCAN_TICK,
   output logic [15:0] DIGITS,
   output logic        RUNNING,
   output logic        ROLLOVER,
   output logic [6:0]  SEG,
   output logic [3:0]  AN
);
   typedef enum logic {PAUSED, RUN} state_t;
   state_t state;
   logic [1:0] scan;
   logic [1:0] scan_nxt;
   logic [15:0] digits_nxt;
   logic c0;
   logic c1;
   logic c2;
   logic c3;
   logic inc;
   logic [3:0] sel;
   logic [6:0] pat;
   always_comb begin
      inc = TICK && state == RUN;
      c0 = DIGITS[3:0] == 4'd9;
      c1 = c0 && DIGITS[7:4] == 4'd5;
      c2 = c1 && DIGITS[11:8] == 4'd9;
      c3 = c2 && DIGITS[15:12] == 4'd5;
      digits_nxt[3:0] = c0 ? 4'd0 : DIGITS[3:0] + 4'd1;
      digits_nxt[7:4] = c1 ? 4'd0 : c0 ? DIGITS[7:4] + 4'd1 : DIGITS[7:4];
      digits_nxt[11:8] = c2 ? 4'd0 : c1 ? DIGITS[11:8] + 4'd1 : DIGITS[11:8];
      digits_nxt[15:12] = c3 ? 4'd0 : c2 ? DIGITS[15:12] + 4'd1 : DIGITS[15:12];
      scan_nxt = scan + {1'b0, SCAN_TICK};
      sel = DIGITS[{scan_nxt, 2'b00} +: 4];
      pat = 7'b0111111;
      case (sel)
         4'd1: pat = 7'b0000110;
         4'd2: pat = 7'b1011011;
         4'd3: pat = 7'b1001111;
         4'd4: pat = 7'b1100110;
         4'd5: pat = 7'b1101101;
         4'd6: pat = 7'b1111101;
         4'd7: pat = 7'b0000111;
         4'd8: pat = 7'b1111111;
         4'd9: pat = 7'b1101111;
         default: pat = 7'b0111111;
      endcase
   end
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state <= PAUSED;
         DIGITS <= '0;
         ROLLOVER <= 1'b0;
         scan <= 2'd0;
         SEG <= SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
         AN <= SEG_ACTIVE_LOW ? 4'b1110 : 4'b0001;
      end else begin
         if (PAUSE)
            state <= state == RUN ? PAUSED : RUN;
         if (inc)
            DIGITS <= digits_nxt;
         ROLLOVER <= inc && c3;
         scan <= scan_nxt;
         SEG <= SEG_ACTIVE_LOW ? ~pat : pat;
         AN <= SEG_ACTIVE_LOW ? ~(4'b0001 << scan_nxt) : 4'b0001 << scan_nxt;
      end
   assign RUNNING = state == RUN;
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: randomized scoreboard bench for stopwatch_display against a seconds-count model
module tb_stopwatch_display;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic TICK = 1'b0;
   logic PAUSE = 1'b0;
   logic SCAN_TICK = 1'b0;
   logic [15:0] DIGITS;
   logic RUNNING;
   logic ROLLOVER;
   logic [6:0] SEG;
   logic [3:0] AN;
   int total = 0;
   int bad = 0;
   typedef struct {
      logic [15:0] d;
      logic run;
      logic roll;
      logic [6:0] seg;
      logic [3:0] an;
   } exp_t;
   exp_t q[$];
   int secs = 0;
   int scan = 0;
   bit run = 1'b0;
   logic [6:0] pat [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

   stopwatch_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
      .CLK(CLK), .RESET(RESET), .TICK(TICK), .PAUSE(PAUSE), .SCAN_TICK(SCAN_TICK),
      .DIGITS(DIGITS), .RUNNING(RUNNING), .ROLLOVER(ROLLOVER), .SEG(SEG), .AN(AN)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] bcd(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   function automatic int digit_at(input int s, input int i);
      logic [15:0] b;
      b = bcd(s);
      return int'(b[4*i +: 4]);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit t, input bit p, input bit sc);
      exp_t e;
      int old;
      @(negedge CLK);
      #1;
      TICK = t;
      PAUSE = p;
      SCAN_TICK = sc;
      old = secs;
      e.roll = t && run && secs == 3599;
      if (t && run) secs = (secs + 1) % 3600;
      if (p) run = !run;
      if (sc) scan = (scan + 1) % 4;
      e.d = bcd(secs);
      e.run = run;
      e.an = ~(4'b0001 << scan);
      e.seg = ~pat[digit_at(old, scan)];
      q.push_back(e);
      @(posedge CLK);
      #1;
      TICK = 0;
      PAUSE = 0;
      SCAN_TICK = 0;
   endtask

   always @(negedge CLK)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("digits", DIGITS, e.d);
         chk("running", 16'(RUNNING), 16'(e.run));
         chk("rollover", 16'(ROLLOVER), 16'(e.roll));
         chk("an", 16'(AN), 16'(e.an));
         chk("seg", 16'(SEG), 16'(e.seg));
      end

   initial begin
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1;
      RESET = 0;
      #1;
      chk("rst_digits", DIGITS, 16'h0000);
      chk("rst_running", 16'(RUNNING), 16'h0);
      chk("rst_rollover", 16'(ROLLOVER), 16'h0);
      chk("rst_an", 16'(AN), 16'h000e);
      chk("rst_seg", 16'(SEG), 16'h0040);
      step(0, 0, 0);
      step(0, 1, 0);
      repeat (10) step(1, 0, 0);
      repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      if (!run) step(0, 1, 0);
      while (secs != 3599) step(1, 0, 1'($urandom_range(0, 1)));
      step(1, 0, 0);
      step(0, 0, 0);
      repeat (5) step(1, 0, 0);
      step(1, 1, 0);
      repeat (3) step(1, 0, 0);
      step(1, 1, 0);
      while (secs != 754) step(1, 0, 0);
      repeat (5) step(0, 0, 1);
      @(negedge CLK);
      #2;
      TICK = 1;
      RESET = 1;
      #1;
      chk("async_digits", DIGITS, 16'h0000);
      chk("async_running", 16'(RUNNING), 16'h0);
      chk("async_an", 16'(AN), 16'h000e);
      chk("async_seg", 16'(SEG), 16'h0040);
      @(posedge CLK);
      @(negedge CLK);
      #1;
      RESET = 0;
      TICK = 0;
      #1;
      chk("post_rst_digits", DIGITS, 16'h0000);
      chk("post_rst_running", 16'(RUNNING), 16'h0);
      secs = 0;
      run = 0;
      scan = 0;
      repeat (200) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      repeat (2) @(negedge CLK);
      #1;
      chk("queue_drained", 16'(q.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
